// File: rtl/short_block_reorder_if.sv
// Stream bus around the short-block reorder stage: requantized lines and side
// info in, frequency-ordered lines out under a valid/ready handshake.
interface short_block_reorder_if #(
  parameter int DATA_W = 16,
  parameter int EXP_W  = 10
);
  logic              window_switching_flag;
  logic [1:0]        block_type;
  logic              mixed_block_flag;
  logic [DATA_W-1:0] x_in;
  logic [EXP_W-1:0]  x_base_in;
  logic              din_valid;
  logic [DATA_W-1:0] x_out;
  logic [EXP_W-1:0]  x_base_out;
  logic              dout_valid;
  logic              dout_ready;
  logic              gr_done;

  // Upstream/downstream side (drives lines, consumes the reordered stream)
  modport master (
    output window_switching_flag, block_type, mixed_block_flag,
    output x_in, x_base_in, din_valid, dout_ready,
    input  x_out, x_base_out, dout_valid, gr_done
  );

  // Reorder block side
  modport slave (
    input  window_switching_flag, block_type, mixed_block_flag,
    input  x_in, x_base_in, din_valid, dout_ready,
    output x_out, x_base_out, dout_valid, gr_done
  );
endinterface

// File: rtl/short_block_reorder.sv
// Short-block reorder: writes one 576-line granule into a ping-pong buffer in
// decode order, scattering short-block lines to their frequency-order slot,
// then streams the bank out sequentially over valid/ready.
module short_block_reorder #(
  parameter int DATA_W = 16,
  parameter int EXP_W  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  short_block_reorder_if.slave bus,
  output logic                 overrun
);
  localparam int         GR_LEN = 576;
  localparam int         WORD_W = DATA_W + EXP_W;
  localparam logic [9:0] LAST_N = 10'(GR_LEN - 1);
  localparam logic [9:0] END_N  = 10'(GR_LEN);
  localparam logic [9:0] MIX_N  = 10'd36;

  // 44.1 kHz short scalefactor band widths
  function automatic logic [5:0] short_width(input logic [3:0] sfb);
    case (sfb)
      4'd0, 4'd1, 4'd2, 4'd3: short_width = 6'd4;
      4'd4:    short_width = 6'd6;
      4'd5:    short_width = 6'd8;
      4'd6:    short_width = 6'd10;
      4'd7:    short_width = 6'd12;
      4'd8:    short_width = 6'd14;
      4'd9:    short_width = 6'd18;
      4'd10:   short_width = 6'd22;
      4'd11:   short_width = 6'd30;
      default: short_width = 6'd56;
    endcase
  endfunction

  logic [WORD_W-1:0] mem [2][GR_LEN];

  // Write side state
  logic [9:0] wr_n_q;
  logic       wr_bank_q;
  logic [1:0] full_q, full_d;
  logic       short_q, mixed_q;
  logic [3:0] sfb_q;
  logic [1:0] win_q;
  logic [5:0] line_q;
  logic [7:0] line3_q;
  logic [9:0] base3_q;
  logic       overrun_q;

  logic       short_g, mixed_g, wr_en, wr_last, in_short;
  logic [5:0] width;
  logic [9:0] width3, wr_addr;

  // Read side state
  logic              rd_bank_q;
  logic [9:0]        issue_q;
  logic [9:0]        pop_cnt_q;
  logic              inflight_q;
  logic [WORD_W-1:0] ram_q;
  logic [WORD_W-1:0] out_q, skid_q;
  logic              out_v_q, skid_v_q;

  logic       pop, rd_release, rd_en;
  logic [1:0] occ_next;

  // Write address generation; side info is taken live on line 0, latched after
  always_comb begin
    short_g = short_q;
    mixed_g = mixed_q;
    if (wr_n_q == '0) begin
      short_g = bus.window_switching_flag && (bus.block_type == 2'd2);
      mixed_g = bus.mixed_block_flag;
    end
    wr_en    = bus.din_valid && !full_q[wr_bank_q];
    wr_last  = (wr_n_q == LAST_N);
    in_short = short_g && !(mixed_g && (wr_n_q < MIX_N));
    width    = short_width(sfb_q);
    width3   = {4'd0, width} + {3'd0, width, 1'b0};
    wr_addr  = in_short ? (base3_q + {2'd0, line3_q} + {8'd0, win_q}) : wr_n_q;
  end

  // Write counters: line/window/band walk with running 3x offsets
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_n_q    <= '0;
      wr_bank_q <= 1'b0;
      short_q   <= 1'b0;
      mixed_q   <= 1'b0;
      sfb_q     <= '0;
      win_q     <= '0;
      line_q    <= '0;
      line3_q   <= '0;
      base3_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (bus.din_valid && full_q[wr_bank_q]) overrun_q <= 1'b1;
      if (wr_en) begin
        if (wr_n_q == '0) begin
          short_q <= short_g;
          mixed_q <= mixed_g;
        end
        if (wr_last) begin
          wr_n_q    <= '0;
          wr_bank_q <= ~wr_bank_q;
          sfb_q     <= '0;
          win_q     <= '0;
          line_q    <= '0;
          line3_q   <= '0;
          base3_q   <= '0;
        end else begin
          wr_n_q <= wr_n_q + 10'd1;
          if (in_short) begin
            if (line_q == width - 6'd1) begin
              line_q  <= '0;
              line3_q <= '0;
              if (win_q == 2'd2) begin
                win_q   <= '0;
                sfb_q   <= sfb_q + 4'd1;
                base3_q <= base3_q + width3;
              end else begin
                win_q <= win_q + 2'd1;
              end
            end else begin
              line_q  <= line_q + 6'd1;
              line3_q <= line3_q + 8'd3;
            end
          end else if (short_g && mixed_g && (wr_n_q == MIX_N - 10'd1)) begin
            // mixed block: short region starts at band 3, i.e. address 36
            sfb_q   <= 4'd3;
            base3_q <= MIX_N;
          end
        end
      end
    end
  end

  // Buffer write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank_q][wr_addr] <= {bus.x_base_in, bus.x_in};
  end

  // Read issue: credit check keeps in-flight + held words within output+skid
  always_comb begin
    pop        = out_v_q && bus.dout_ready;
    rd_release = pop && (pop_cnt_q == LAST_N);
    occ_next   = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q} - {1'b0, pop};
    rd_en      = full_q[rd_bank_q] && (issue_q != END_N) && (occ_next < 2'd2);
  end

  // Bank full flags: a fill and a release may land in the same cycle
  always_comb begin
    full_d = full_q;
    if (wr_en && wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_release)       full_d[rd_bank_q] = 1'b0;
  end

  // Bank occupancy register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= '0;
    else     full_q <= full_d;
  end

  // Buffer read port, one-cycle latency
  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[rd_bank_q][issue_q];
  end

  // Output register with skid slot so a word arriving during a stall is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q  <= 1'b0;
      issue_q    <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
      out_v_q    <= 1'b0;
      skid_v_q   <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (rd_release) begin
        rd_bank_q <= ~rd_bank_q;
        issue_q   <= '0;
        pop_cnt_q <= '0;
      end else begin
        if (rd_en) issue_q   <= issue_q + 10'd1;
        if (pop)   pop_cnt_q <= pop_cnt_q + 10'd1;
      end
      if (!out_v_q || pop) begin
        if (skid_v_q) begin
          out_q    <= skid_q;
          out_v_q  <= 1'b1;
          skid_v_q <= inflight_q;
          if (inflight_q) skid_q <= ram_q;
        end else begin
          out_v_q  <= inflight_q;
          skid_v_q <= 1'b0;
          if (inflight_q) out_q <= ram_q;
        end
      end else if (inflight_q) begin
        skid_q   <= ram_q;
        skid_v_q <= 1'b1;
      end
    end
  end

  assign bus.x_out      = out_q[DATA_W-1:0];
  assign bus.x_base_out = out_q[WORD_W-1:DATA_W];
  assign bus.dout_valid = out_v_q;
  assign bus.gr_done    = rd_release;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_short_block_reorder.sv
// Bench for short_block_reorder: random granules scored against a queue-based
// frequency-order model, plus directed position, overrun and reset checks.
module tb_short_block_reorder;
  localparam int DATA_W = 16;
  localparam int EXP_W  = 10;
  localparam int GR_LEN = 576;

  logic clk = 1'b0;
  logic rst;
  logic overrun;
  always #5 clk = ~clk;

  short_block_reorder_if #(.DATA_W(DATA_W), .EXP_W(EXP_W)) bus ();

  short_block_reorder #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .overrun (overrun)
  );

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [EXP_W-1:0]  e;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  bit   gap_chk = 1'b0;
  int   sw[13] = '{4, 4, 4, 4, 6, 8, 10, 12, 14, 18, 22, 30, 56};

  logic [DATA_W-1:0] rx_x[GR_LEN];
  int                rx_pos;
  int                gap;
  bit                after_last;
  bit                stall_q;
  logic [31:0]       held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  // Downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.dout_ready = 1'b1;
      1:       bus.dout_ready = ($urandom_range(7) != 0);
      default: bus.dout_ready = 1'b0;
    endcase
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stall_q    = 1'b0;
      rx_pos     = 0;
      gap        = 0;
      after_last = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(bus.dout_valid), 32'd1);
        chk("hold_word", {6'd0, bus.x_base_out, bus.x_out}, held);
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(bus.dout_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("x_out", 32'(bus.x_out), 32'(mon_e.x));
          chk("x_base_out", 32'(bus.x_base_out), 32'(mon_e.e));
          chk("gr_done", 32'(bus.gr_done), 32'(mon_e.last));
          if (after_last && gap_chk) chk("idle_gap_le2", 32'(gap <= 2), 32'd1);
          after_last = mon_e.last && (exp_q.size() != 0);
        end
        gap = 0;
        rx_x[rx_pos] = bus.x_out;
        rx_pos = (rx_pos == GR_LEN - 1) ? 0 : rx_pos + 1;
      end else begin
        chk("gr_done_no_accept", 32'(bus.gr_done), 32'd0);
        gap++;
      end
      stall_q = bus.dout_valid && !bus.dout_ready;
      held    = {6'd0, bus.x_base_out, bus.x_out};
    end
  end

  // mode: 0 long, 1 short, 2 mixed. keep: model expects the granule out.
  task automatic send_granule(input int mode, input bit rnd, input bit gaps,
                              input bit keep, input int stop_at);
    logic [DATA_W-1:0] xs[GR_LEN];
    logic [EXP_W-1:0]  es[GR_LEN];
    logic [DATA_W-1:0] ox[GR_LEN];
    logic [EXP_W-1:0]  oe[GR_LEN];
    int pos[GR_LEN];
    int n, start, first;
    exp_t w;
    for (int i = 0; i < GR_LEN; i++) begin
      xs[i]  = rnd ? DATA_W'($urandom) : DATA_W'(i);
      es[i]  = rnd ? EXP_W'($urandom) : EXP_W'(i);
      pos[i] = i;
    end
    if (mode != 0) begin
      n = 0; first = 0; start = 0;
      if (mode == 2) begin n = 36; first = 3; start = 12; end
      for (int b = first; b < 13; b++) begin
        for (int wn = 0; wn < 3; wn++)
          for (int l = 0; l < sw[b]; l++) begin
            pos[n] = 3 * start + 3 * l + wn;
            n++;
          end
        start += sw[b];
      end
    end
    for (int i = 0; i < GR_LEN; i++) begin
      ox[pos[i]] = xs[i];
      oe[pos[i]] = es[i];
    end
    if (keep)
      for (int p = 0; p < GR_LEN; p++) begin
        w.x = ox[p]; w.e = oe[p]; w.last = (p == GR_LEN - 1);
        exp_q.push_back(w);
      end
    n = 0;
    while (n < stop_at) begin
      @(posedge clk); #1;
      bus.window_switching_flag = 1'($urandom);
      bus.block_type            = 2'($urandom);
      bus.mixed_block_flag      = 1'($urandom);
      if (gaps && $urandom_range(3) == 0) begin
        bus.din_valid = 1'b0;
      end else begin
        if (n == 0) begin
          if (mode == 0) begin
            if (bus.window_switching_flag) bus.block_type = ($urandom_range(1) == 0) ? 2'd1 : 2'd3;
          end else begin
            bus.window_switching_flag = 1'b1;
            bus.block_type            = 2'd2;
            bus.mixed_block_flag      = (mode == 2);
          end
        end
        bus.x_in      = xs[n];
        bus.x_base_in = es[n];
        bus.din_valid = 1'b1;
        n++;
      end
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
      bus.din_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.x_in = '0;
    bus.x_base_in = '0;
    bus.window_switching_flag = 1'b0;
    bus.block_type = 2'd0;
    bus.mixed_block_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_x_out", 32'(bus.x_out), 32'd0);
    chk("rst_x_base_out", 32'(bus.x_base_out), 32'd0);
    chk("rst_gr_done", 32'(bus.gr_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // long granule, identity order
    send_granule(0, 1'b0, 1'b0, 1'b1, GR_LEN); idle(1); wait_drain();
    chk("long_pos0", 32'(rx_x[0]), 32'd0);
    chk("long_pos300", 32'(rx_x[300]), 32'd300);
    chk("long_pos575", 32'(rx_x[575]), 32'd575);

    // short, non-mixed
    send_granule(1, 1'b0, 1'b1, 1'b1, GR_LEN); idle(1); wait_drain();
    chk("short_pos0", 32'(rx_x[0]), 32'd0);
    chk("short_pos1", 32'(rx_x[1]), 32'd4);
    chk("short_pos2", 32'(rx_x[2]), 32'd8);
    chk("short_pos12", 32'(rx_x[12]), 32'd12);
    chk("short_pos408", 32'(rx_x[408]), 32'd408);
    chk("short_pos409", 32'(rx_x[409]), 32'd464);
    chk("short_pos410", 32'(rx_x[410]), 32'd520);
    chk("short_pos575", 32'(rx_x[575]), 32'd575);

    // short, mixed
    send_granule(2, 1'b0, 1'b0, 1'b1, GR_LEN); idle(1); wait_drain();
    chk("mixed_pos20", 32'(rx_x[20]), 32'd20);
    chk("mixed_pos35", 32'(rx_x[35]), 32'd35);
    chk("mixed_pos36", 32'(rx_x[36]), 32'd36);
    chk("mixed_pos37", 32'(rx_x[37]), 32'd40);
    chk("mixed_pos38", 32'(rx_x[38]), 32'd44);

    // back-to-back long then short at full rate
    gap_chk = 1'b1;
    send_granule(0, 1'b1, 1'b0, 1'b1, GR_LEN);
    send_granule(1, 1'b1, 1'b0, 1'b1, GR_LEN);
    idle(1); wait_drain();
    gap_chk = 1'b0;
    chk("b2b_overrun", 32'(overrun), 32'd0);

    // random granules, input gaps and downstream stalls
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      send_granule($urandom_range(2), 1'b1, 1'b1, 1'b1, GR_LEN);
      idle($urandom_range(20) + 1);
    end
    wait_drain();
    ready_mode = 0;
    chk("rand_overrun", 32'(overrun), 32'd0);

    // three granules into a stalled output: third one dropped
    ready_mode = 2;
    send_granule(0, 1'b0, 1'b0, 1'b1, GR_LEN);
    send_granule(1, 1'b1, 1'b0, 1'b1, GR_LEN);
    idle(2);
    @(negedge clk);
    chk("ovr_before", 32'(overrun), 32'd0);
    chk("stall_valid", 32'(bus.dout_valid), 32'd1);
    send_granule(0, 1'b1, 1'b0, 1'b0, GR_LEN);
    idle(2);
    @(negedge clk);
    chk("ovr_after", 32'(overrun), 32'd1);
    ready_mode = 0;
    wait_drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // reset mid-granule with a full bank buffered
    ready_mode = 2;
    send_granule(0, 1'b1, 1'b0, 1'b0, GR_LEN);
    send_granule(0, 1'b1, 1'b0, 1'b0, 300);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.din_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_mode = 0;
    idle(5);
    @(negedge clk);
    chk("no_stale_valid", 32'(bus.dout_valid), 32'd0);
    send_granule(0, 1'b0, 1'b0, 1'b1, GR_LEN); idle(1); wait_drain();
    chk("post_rst_pos575", 32'(rx_x[575]), 32'd575);
    idle(20);
    @(negedge clk);
    chk("final_idle_valid", 32'(bus.dout_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
